// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the multi-cycle core.
// A TX_DATA store starts a frame; STATUS reports Busy plus sticky Done and Overrun.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Reg_Sel,
  input  logic                  Write_En,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Tx,
  output logic                  Busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BaudMax = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          done_q;
  logic          overrun_q;
  logic          done_d;
  logic          overrun_d;

  logic txWrite;
  logic statusWrite;
  logic bitEnd;
  logic frameEnd;
  logic unusedWriteBits;

  assign txWrite         = Write_En && (Reg_Sel == 2'b01);
  assign statusWrite     = Write_En && (Reg_Sel == 2'b10);
  assign bitEnd          = (baud_q == BaudMax);
  assign frameEnd        = (state_q == STOP) && bitEnd;
  assign unusedWriteBits = ^Write_Data[DATA_WIDTH-1:8];

  // Sticky flags: a set event on the same edge as a write-1-to-clear wins.
  always_comb begin
    done_d    = done_q;
    overrun_d = overrun_q;
    if (statusWrite && Write_Data[1]) done_d = 1'b0;
    if (statusWrite && Write_Data[2]) overrun_d = 1'b0;
    if (frameEnd) done_d = 1'b1;
    if (txWrite && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      overrun_q <= overrun_d;
      unique case (state_q)
        IDLE: begin
          if (txWrite) begin
            data_q   <= Write_Data[7:0];
            shift_q  <= Write_Data[7:0];
            baud_q   <= '0;
            bitIdx_q <= '0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          // Tx is loaded one bit ahead so the line only ever changes from a register.
          if (bitEnd) begin
            baud_q <= '0;
            if (bitIdx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Tx   = tx_q;
  assign Busy = (state_q != IDLE);

  always_comb begin
    Read_Data = '0;
    case (Reg_Sel)
      2'b10:   Read_Data[2:0] = {overrun_q, done_q, Busy};
      2'b01:   Read_Data[7:0] = data_q;
      default: Read_Data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio; a monitor captures each frame and checks it
// against bytes queued by the stimulus, while register reads are checked inline.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DW    = 32;
  localparam int FRAME = 10 * CPB;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [1:0]    Reg_Sel    = 2'b00;
  logic          Write_En   = 1'b0;
  logic [DW-1:0] Write_Data = '0;
  logic [DW-1:0] Read_Data;
  logic          Tx;
  logic          Busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .Reg_Sel    (Reg_Sel),
    .Write_En   (Write_En),
    .Write_Data (Write_Data),
    .Read_Data  (Read_Data),
    .Tx         (Tx),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle bus store; inputs change on the falling edge.
  task automatic applyStimulus(input logic [1:0] sel, input logic [DW-1:0] data);
    Reg_Sel    = sel;
    Write_Data = data;
    Write_En   = 1'b1;
    @(negedge clk);
    Write_En   = 1'b0;
    Reg_Sel    = 2'b00;
    Write_Data = '0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit accepted);
    if (accepted) expQ.push_back(b);
    applyStimulus(2'b01, {24'b0, b});
  endtask

  task automatic readReg(input logic [1:0] sel, input logic [DW-1:0] expected,
                         input string name);
    Reg_Sel = sel;
    #1;
    checkOutput(name, Read_Data, expected);
    Reg_Sel = 2'b00;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, Busy}, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: records Tx for every cycle Busy is high and checks the frame shape.
  initial begin : monitor
    logic [FRAME-1:0] got;
    logic [FRAME-1:0] want;
    logic             busyHeld;
    logic             aborted;
    logic [7:0]       b;
    int               bitNum;
    forever begin
      do begin
        @(negedge clk);
        #1;
      end while (Busy !== 1'b1 || reset);
      aborted  = 1'b0;
      busyHeld = 1'b1;
      got      = '0;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) begin
          @(negedge clk);
          #1;
        end
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        got[i]   = Tx;
        busyHeld = busyHeld & Busy;
      end
      if (aborted) begin
        if (expQ.size() > 0) void'(expQ.pop_front());
        continue;
      end
      @(negedge clk);
      #1;
      checkOutput("busyLength", {30'b0, busyHeld, Busy}, 32'h2);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedFrame: got tx pattern 0x%0h, expected no frame", got);
      end else begin
        b = expQ.pop_front();
        for (int i = 0; i < FRAME; i++) begin
          bitNum  = i / CPB;
          want[i] = (bitNum == 0) ? 1'b0 : (bitNum == 9) ? 1'b1 : b[bitNum-1];
        end
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL frameBits(0x%0h): got tx pattern 0x%0h, expected 0x%0h",
                   b, got, want);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    idle(3);
    reset = 1'b0;
    idle(100);
    checkOutput("resetTx", {31'b0, Tx}, 32'h1);
    checkOutput("resetBusy", {31'b0, Busy}, 32'h0);
    readReg(2'b10, 32'h0, "resetStatus");
    readReg(2'b01, 32'h0, "resetData");

    // Single 0x55 frame, then reserved/none selects must not disturb anything.
    sendByte(8'h55, 1'b1);
    waitIdle("idle55");
    readReg(2'b10, 32'h2, "status55");
    readReg(2'b01, 32'h55, "data55");
    readReg(2'b11, 32'h0, "readReserved");
    readReg(2'b00, 32'h0, "readNone");
    applyStimulus(2'b11, 32'h6);
    applyStimulus(2'b00, 32'h41);
    checkOutput("ignoredWriteBusy", {31'b0, Busy}, 32'h0);
    readReg(2'b10, 32'h2, "ignoredWriteStatus");
    applyStimulus(2'b10, 32'h2);
    readReg(2'b10, 32'h0, "doneCleared");

    // Overrun: second byte lands mid-frame and is dropped.
    sendByte(8'hA3, 1'b1);
    idle(4);
    sendByte(8'h0F, 1'b0);
    readReg(2'b10, 32'h5, "statusOverrunBusy");
    readReg(2'b01, 32'hA3, "dataA3");
    waitIdle("idleA3");
    readReg(2'b10, 32'h6, "statusOverrunDone");
    applyStimulus(2'b10, 32'h6);
    readReg(2'b10, 32'h0, "statusCleared");

    // Back-to-back frames: next byte offered in the first Busy=0 cycle.
    sendByte(8'h81, 1'b1);
    waitIdle("idle81");
    sendByte(8'h7E, 1'b1);
    readReg(2'b10, 32'h3, "statusBackToBack");
    waitIdle("idle7E");
    readReg(2'b10, 32'h2, "status7E");
    applyStimulus(2'b10, 32'h2);
    readReg(2'b10, 32'h0, "doneCleared2");

    // Reset in the middle of a frame with Overrun pending.
    sendByte(8'hFF, 1'b1);
    idle(3);
    sendByte(8'h12, 1'b0);
    readReg(2'b10, 32'h5, "statusBeforeReset");
    idle(12);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetTx", {31'b0, Tx}, 32'h1);
    checkOutput("midResetBusy", {31'b0, Busy}, 32'h0);
    readReg(2'b10, 32'h0, "midResetStatus");
    reset = 1'b0;
    idle(2);
    sendByte(8'h00, 1'b1);
    waitIdle("idle00");
    readReg(2'b10, 32'h2, "status00");
    applyStimulus(2'b10, 32'h2);

    // TX write on the edge STOP completes: dropped, Overrun and Done both set.
    sendByte(8'h3C, 1'b1);
    idle(38);
    checkOutput("lastCycleBusy", {31'b0, Busy}, 32'h1);
    idle(1);
    sendByte(8'h99, 1'b0);
    checkOutput("edgeWriteBusy", {31'b0, Busy}, 32'h0);
    readReg(2'b10, 32'h6, "statusEdgeWrite");
    readReg(2'b01, 32'h3C, "data3C");
    applyStimulus(2'b10, 32'h6);
    readReg(2'b10, 32'h0, "statusCleared3");

    // Done clear on the completion edge: set wins.
    sendByte(8'hC5, 1'b1);
    idle(39);
    applyStimulus(2'b10, 32'h2);
    readReg(2'b10, 32'h2, "doneSetWins");

    idle(5);
    checkOutput("queueEmpty", expQ.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
